// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl_if
// Description : Bundle of the ID/EX hazard inputs and the stall/flush/bubble
//               and mult/div status outputs of pipe_hazard_ctrl.
//               slave  = the hazard controller side
//               master = the pipeline side driving ID/EX fields
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_hazard_ctrl_if;
    logic [4:0]  id_Ra;
    logic [4:0]  id_Rb;
    logic        id_useRa;
    logic        id_useRb;
    logic        id_md_use;
    logic [4:0]  ex_Rw;
    logic [1:0]  ex_MemRead;
    logic        ex_md_start;
    logic        ex_BranchTaken;
    logic        pc_stall;
    logic        ifid_stall;
    logic        ifid_flush;
    logic        hazard;
    logic        BranchBubble;
    logic        md_busy;
    logic        md_done;
    logic [31:0] stall_cnt;

    modport slave (
        input  id_Ra, id_Rb, id_useRa, id_useRb, id_md_use,
        input  ex_Rw, ex_MemRead, ex_md_start, ex_BranchTaken,
        output pc_stall, ifid_stall, ifid_flush, hazard, BranchBubble,
        output md_busy, md_done, stall_cnt
    );

    modport master (
        output id_Ra, id_Rb, id_useRa, id_useRb, id_md_use,
        output ex_Rw, ex_MemRead, ex_md_start, ex_BranchTaken,
        input  pc_stall, ifid_stall, ifid_flush, hazard, BranchBubble,
        input  md_busy, md_done, stall_cnt
    );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Hazard/sequencing controller for the 5-stage MIPS pipeline.
//               Load-use and mult/div-dependency stalls, taken-branch flush,
//               and a latency counter for the multi-cycle mult/div unit.
//               Optional macro PIPE_HAZARD_PERF_EN builds a saturating
//               stall/flush cycle counter; otherwise stall_cnt is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int MD_LATENCY = 32            // legal range 1..255
) (
    input  wire logic         Clk,
    input  wire logic         Rst,
    pipe_hazard_ctrl_if.slave bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [7:0] C_MD_LOAD = 8'(MD_LATENCY - 1);

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nxt;

    logic       w_md_busy;
    logic       w_ldu;
    logic       w_mdc;
    logic       w_stl;

    // MD state and latency counter registers
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // MD next state: starts are only accepted in IDLE; a branch never cancels
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (bus.ex_md_start) begin
                    w_state_nxt = S_BUSY;
                    w_cnt_nxt   = C_MD_LOAD;
                end
            end
            S_BUSY: begin
                if (r_cnt == 8'd0) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 8'd0;
            end
        endcase
    end

    assign w_md_busy = (r_state == S_BUSY) || (r_state == S_DONE);

    assign w_ldu = (bus.ex_MemRead != 2'b00) && (bus.ex_Rw != 5'd0) &&
                   ((bus.id_useRa && (bus.id_Ra == bus.ex_Rw)) ||
                    (bus.id_useRb && (bus.id_Rb == bus.ex_Rw)));
    assign w_mdc = bus.id_md_use && (w_md_busy || bus.ex_md_start);
    assign w_stl = w_ldu || w_mdc;

    // Outputs: branch flush outranks any stall; everything quiet during reset
    always_comb begin
        bus.pc_stall     = 1'b0;
        bus.ifid_stall   = 1'b0;
        bus.ifid_flush   = 1'b0;
        bus.hazard       = 1'b0;
        bus.BranchBubble = 1'b0;
        bus.md_busy      = w_md_busy;
        bus.md_done      = (r_state == S_DONE);
        if (!Rst) begin
            if (bus.ex_BranchTaken) begin
                bus.ifid_flush   = 1'b1;
                bus.BranchBubble = 1'b1;
            end else if (w_stl) begin
                bus.pc_stall   = 1'b1;
                bus.ifid_stall = 1'b1;
                bus.hazard     = 1'b1;
            end
        end
    end

`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] r_stall_cnt;

    // Saturating count of cycles lost to stalls or flushes
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_stall_cnt <= 32'd0;
        end else if ((bus.pc_stall || bus.ifid_flush) &&
                     (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign bus.stall_cnt = r_stall_cnt;
`else
    assign bus.stall_cnt = 32'd0;
`endif

endmodule
`default_nettype wire
